// File: rtl/dnn_layer_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dnn_layer_seq: issues the dnn_acc command sequence for one inference,    |
// | with abort and a per-command watchdog.                 Revision: 1.0     |
// +--------------------------------------------------------------------------+
module dnn_layer_seq #(
  parameter int TIMEOUT_W      = 20,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_HL         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dnn_start,
  input  logic       dnn_abort,
  input  logic [2:0] hidden_layers,
  output logic       cmd_start,
  output logic [1:0] cmd,
  output logic       cmd_buf_sel,
  output logic [2:0] cmd_cur_layer,
  input  logic       cmd_done,
  output logic       dnn_done,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0]           c_cmd_load_input = 2'b00;
  localparam logic [1:0]           c_cmd_load_param = 2'b01;
  localparam logic [1:0]           c_cmd_compute    = 2'b10;
  localparam logic [1:0]           c_cmd_store      = 2'b11;
  localparam logic [2:0]           c_max_hl         = 3'(MAX_HL);
  localparam logic [TIMEOUT_W-1:0] c_wdog_last      = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [2:0]           nl_q, nl_d;
  logic [3:0]           idx_q, idx_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 err_q, err_d;
  logic [1:0]           cmd_q, cmd_d;
  logic                 buf_q, buf_d;
  logic [2:0]           layer_q, layer_d;

  logic [3:0] last_idx;
  logic [3:0] k;
  logic [1:0] dec_cmd;
  logic       dec_buf;
  logic [2:0] dec_layer;

  // Command index: 0 = LOAD_INPUT, then LOAD_PARAM/COMPUTE pairs per layer, last = STORE.
  always_comb begin
    last_idx  = {nl_q, 1'b0} + 4'd3;
    k         = idx_q - 4'd1;
    dec_cmd   = c_cmd_load_input;
    dec_buf   = 1'b0;
    dec_layer = 3'd0;
    if (idx_q == 4'd0) begin
      dec_cmd = c_cmd_load_input;
    end else if (idx_q == last_idx) begin
      dec_cmd   = c_cmd_store;
      dec_buf   = ~nl_q[0];
      dec_layer = nl_q;
    end else begin
      dec_layer = k[3:1];
      if (k[0]) begin
        dec_cmd = c_cmd_compute;
        dec_buf = k[1];
      end else begin
        dec_cmd = c_cmd_load_param;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    nl_d    = nl_q;
    idx_d   = idx_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    cmd_d   = cmd_q;
    buf_d   = buf_q;
    layer_d = layer_q;
    if (state_q != ST_IDLE && dnn_abort) begin
      state_d = ST_IDLE;
      cmd_d   = 2'd0;
      buf_d   = 1'b0;
      layer_d = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dnn_start && !dnn_abort) begin
            nl_d    = (hidden_layers > c_max_hl) ? c_max_hl : hidden_layers;
            idx_d   = 4'd0;
            err_d   = 1'b0;
            state_d = ST_NEXT;
          end
        end
        ST_NEXT: begin
          // The pointer advances on completion, so here it already names the next command.
          if (idx_q > last_idx) begin
            state_d = ST_DONE;
          end else begin
            cmd_d   = dec_cmd;
            buf_d   = dec_buf;
            layer_d = dec_layer;
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wdog_d  = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (cmd_done) begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_NEXT;
          end else if (wdog_q == c_wdog_last) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
            cmd_d   = 2'd0;
            buf_d   = 1'b0;
            layer_d = 3'd0;
          end else begin
            wdog_d = wdog_q + TIMEOUT_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          cmd_d   = 2'd0;
          buf_d   = 1'b0;
          layer_d = 3'd0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      nl_q    <= 3'd0;
      idx_q   <= 4'd0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
      cmd_q   <= 2'd0;
      buf_q   <= 1'b0;
      layer_q <= 3'd0;
    end else begin
      state_q <= state_d;
      nl_q    <= nl_d;
      idx_q   <= idx_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      cmd_q   <= cmd_d;
      buf_q   <= buf_d;
      layer_q <= layer_d;
    end
  end

  assign cmd_start     = (state_q == ST_ISSUE);
  assign dnn_done      = (state_q == ST_DONE);
  assign busy          = (state_q == ST_NEXT) || (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign err           = err_q;
  assign cmd           = cmd_q;
  assign cmd_buf_sel   = buf_q;
  assign cmd_cur_layer = layer_q;

endmodule
`default_nettype wire

// File: tb/tb_dnn_layer_seq.sv
`default_nettype none
// Bench for dnn_layer_seq: command-list model plus dnn_acc responder.
module tb_dnn_layer_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dnn_start = 1'b0;
  logic       dnn_abort = 1'b0;
  logic [2:0] hidden_layers = 3'd0;
  logic       cmd_start;
  logic [1:0] cmd;
  logic       cmd_buf_sel;
  logic [2:0] cmd_cur_layer;
  logic       cmd_done = 1'b0;
  logic       dnn_done;
  logic       busy;
  logic       err;

  dnn_layer_seq #(.TIMEOUT_W(20), .TIMEOUT_CYCLES(50), .MAX_HL(4)) dut (
    .clk(clk), .rst_n(rst_n), .dnn_start(dnn_start), .dnn_abort(dnn_abort),
    .hidden_layers(hidden_layers), .cmd_start(cmd_start), .cmd(cmd),
    .cmd_buf_sel(cmd_buf_sel), .cmd_cur_layer(cmd_cur_layer), .cmd_done(cmd_done),
    .dnn_done(dnn_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected command words {cmd, buf_sel, layer} for one inference.
  logic [5:0] exp_q[$];
  logic [5:0] log_q[$];
  int         cmds_seen = 0;
  bit         exp_done_pending = 0;
  bit         first_pending = 0;
  bit         outstanding = 0;
  int         start_cyc = 0;
  int         last_done_cyc = 0;
  bit         acc_en = 1;

  function automatic void build(input logic [2:0] hl);
    int nl;
    exp_q.delete();
    nl = (hl > 3'd4) ? 4 : int'(hl);
    exp_q.push_back({2'd0, 1'b0, 3'd0});
    for (int l = 0; l <= nl; l++) begin
      exp_q.push_back({2'd1, 1'b0, 3'(l)});
      exp_q.push_back({2'd2, 1'(l % 2), 3'(l)});
    end
    exp_q.push_back({2'd3, 1'((nl + 1) % 2), 3'(nl)});
  endfunction

  // dnn_acc responder: cmd_done five cycles after each cmd_start.
  initial forever begin
    @(negedge clk);
    if (cmd_start && acc_en) begin
      repeat (5) @(posedge clk);
      #1 cmd_done = 1'b1;
      @(posedge clk);
      #1 cmd_done = 1'b0;
    end
  end

  // Compare process.
  initial forever begin
    logic [5:0] w;
    logic [5:0] e;
    @(negedge clk);
    if (rst_n) begin
      if (cmd_done && outstanding) begin
        last_done_cyc = cyc;
        outstanding   = 0;
      end
      if (cmd_start) begin
        w = {cmd, cmd_buf_sel, cmd_cur_layer};
        log_q.push_back(w);
        cmds_seen++;
        if (first_pending) begin
          chk("first cmd_start latency", 32'(cyc - start_cyc), 32'd2);
          first_pending = 0;
        end else begin
          chk("cmd_done to cmd_start gap", 32'(cyc - last_done_cyc), 32'd2);
        end
        if (exp_q.size() == 0) chk("unexpected cmd_start", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("command word", 32'(w), 32'(e));
        end
        outstanding = 1;
      end
      if (dnn_done) begin
        chk("dnn_done expected", 32'(exp_done_pending), 32'd1);
        chk("commands left at dnn_done", 32'(exp_q.size()), 32'd0);
        chk("busy in done cycle", 32'(busy), 32'd0);
        exp_done_pending = 0;
      end
    end
  end

  task automatic start_pulse(input logic [2:0] hl);
    @(posedge clk);
    #1;
    dnn_start     = 1'b1;
    hidden_layers = hl;
    start_cyc     = cyc;
    first_pending = 1;
    cmds_seen     = 0;
    log_q.delete();
    @(posedge clk);
    #1;
    dnn_start     = 1'b0;
    hidden_layers = ~hl;  // must not affect the running sequence
  endtask

  task automatic wait_cmds(input int n, input string name);
    int t = 0;
    while (cmds_seen < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (cmds_seen < n) chk(name, 32'(cmds_seen), 32'(n));
  endtask

  task automatic run_seq(input logic [2:0] hl);
    int t = 0;
    build(hl);
    exp_done_pending = 1;
    start_pulse(hl);
    @(negedge clk);
    chk("busy after start", 32'(busy), 32'd1);
    chk("err cleared by start", 32'(err), 32'd0);
    while (exp_done_pending && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_done_pending) begin
      chk("dnn_done within budget", 32'd0, 32'd1);
      exp_done_pending = 0;
    end
    @(negedge clk);
    chk("busy low after done", 32'(busy), 32'd0);
    chk("cmd_start idle after done", 32'(cmd_start), 32'd0);
  endtask

  initial begin
    int t;
    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset cmd_start", 32'(cmd_start), 32'd0);
    chk("reset cmd", 32'(cmd), 32'd0);
    chk("reset buf_sel", 32'(cmd_buf_sel), 32'd0);
    chk("reset layer", 32'(cmd_cur_layer), 32'd0);
    chk("reset dnn_done", 32'(dnn_done), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // hidden_layers = 0: four commands.
    run_seq(3'd0);
    chk("hl0 command count", 32'(cmds_seen), 32'd4);
    if (log_q.size() == 4) begin
      chk("hl0 cmd0", 32'(log_q[0]), 32'h00);
      chk("hl0 cmd1", 32'(log_q[1]), 32'h10);
      chk("hl0 cmd2", 32'(log_q[2]), 32'h20);
      chk("hl0 cmd3", 32'(log_q[3]), 32'h38);
    end

    // hidden_layers = 3: ten commands, computes alternate buffers.
    run_seq(3'd3);
    chk("hl3 command count", 32'(cmds_seen), 32'd10);
    if (log_q.size() == 10) begin
      chk("hl3 compute L1", 32'(log_q[4]), 32'h29);
      chk("hl3 compute L3", 32'(log_q[8]), 32'h2B);
      chk("hl3 store", 32'(log_q[9]), 32'h33);
    end

    // hidden_layers = 7 clamps to 4.
    run_seq(3'd7);
    chk("hl7 command count", 32'(cmds_seen), 32'd12);
    if (log_q.size() == 12) begin
      chk("hl7 last compute", 32'(log_q[10]), 32'h24);
      chk("hl7 store", 32'(log_q[11]), 32'h3C);
    end

    // Watchdog: responder silent.
    acc_en = 0;
    build(3'd1);
    exp_done_pending = 0;
    start_pulse(3'd1);
    t = 0;
    while (!err && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("watchdog err set", 32'(err), 32'd1);
    chk("watchdog latency", 32'(cyc - start_cyc), 32'd53);
    chk("busy after timeout", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("err sticky", 32'(err), 32'd1);
    chk("commands before timeout", 32'(cmds_seen), 32'd1);
    exp_q.delete();
    outstanding = 0;
    acc_en = 1;
    run_seq(3'd0);

    // Second start ignored, then abort during a COMPUTE.
    build(3'd2);
    exp_done_pending = 0;
    start_pulse(3'd2);
    wait_cmds(3, "reach third command");
    @(posedge clk);
    #1 dnn_start = 1'b1;
    @(posedge clk);
    #1 dnn_start = 1'b0;
    wait_cmds(5, "reach second compute");
    chk("abort target is compute", 32'(cmd), 32'd2);
    @(posedge clk);
    #1 dnn_abort = 1'b1;
    @(posedge clk);
    #1 dnn_abort = 1'b0;
    @(negedge clk);
    chk("busy after abort", 32'(busy), 32'd0);
    chk("err after abort", 32'(err), 32'd0);
    repeat (20) @(negedge clk);
    chk("no cmd_start after abort", 32'(cmds_seen), 32'd5);
    exp_q.delete();
    outstanding = 0;

    // Asynchronous reset mid-WAIT, then a fresh run.
    build(3'd1);
    exp_done_pending = 0;
    start_pulse(3'd1);
    wait_cmds(5, "reach compute before reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async reset cmd", 32'(cmd), 32'd0);
    chk("async reset buf_sel", 32'(cmd_buf_sel), 32'd0);
    chk("async reset layer", 32'(cmd_cur_layer), 32'd0);
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset cmd_start", 32'(cmd_start), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    outstanding = 0;
    repeat (8) @(posedge clk);
    run_seq(3'd2);
    chk("post-reset command count", 32'(cmds_seen), 32'd8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
